mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the shared 4-to-1, 2-bit mux datapath.
//  - Four requesters each present a 2-bit word; the block picks one, drives the mux select and registers the result.
//  - Presents the result on a valid/ready output port.
//  - Replaces the testbench-driven sel stepping with fair, handshaked sharing.

---
 rtl/mux4_arb_pkg.sv | 32 +++
 rtl/rr_pick4.sv | 22 ++
 rtl/mux4_rr_arbiter.sv | 97 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
// The state enum always carries LOCKED; it is only ever reached when the
// design is built with MUX4_ARB_LOCK_EN defined.
package mux4_arb_pkg;

  localparam int DW   = 2;
  localparam int NREQ = 4;
  localparam logic [1:0] SEL_RST = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // First set request bit scanning upward from last+1, wrapping mod 4.
  // The last winner itself is checked last, so it has the lowest priority.
  // Returns last when no bit is set; callers qualify the result with |req.
  function automatic logic [1:0] next_idx(input logic [1:0] last,
                                          input logic [3:0] req);
    logic [1:0] r;
    logic [1:0] c;
    r = last;
    // Scan from the lowest priority toward the highest so the highest wins.
    for (int k = 4; k >= 1; k--) begin
      c = last + k[1:0];
      if (req[c]) r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority encoder for four requesters.
// Priority starts just above 'last' and wraps; 'idx' and 'onehot' are only
// meaningful while 'any' is high (onehot is forced to zero otherwise).
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] idx,
  output logic [3:0] onehot
);

  // Rotating first-set search plus one-hot expansion of the winner.
  always_comb begin
    any    = |req;
    idx    = next_idx(last, req);
    onehot = 4'b0000;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-to-1, 2-bit mux datapath.
// Four requesters offer a word each; one is picked in rotating order, acked
// combinationally, and its word registered onto a valid/ready output port.
// Optional burst lock is compiled in with the macro MUX4_ARB_LOCK_EN: a
// capture taken with lock=1 restricts the next capture to the same requester.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MUX4_ARB_LOCK_EN
  input  logic                 lock,
`endif
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   in_data,
  output logic [NREQ-1:0]      ack,
  output logic [1:0]           sel,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  state_t            state;
  logic              slot_free;
  logic [NREQ-1:0]   eligible;
  logic              pick_any;
  logic [1:0]        pick_idx;
  logic [NREQ-1:0]   pick_onehot;
  logic              capture;
  logic [DW-1:0]     words [NREQ];
  logic [DW-1:0]     win_data;

  // Unpack the flat input bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign words[gi] = in_data[DW*gi +: DW];
  end

  // The output slot can take a new word when empty or being consumed now.
  // IDLE always coincides with out_valid=0, so the state stands in for it.
  assign slot_free = (state == IDLE) | out_ready;

  // Requests allowed to compete this cycle; under lock only the locked
  // requester competes while it keeps requesting, otherwise the lock lapses.
`ifdef MUX4_ARB_LOCK_EN
  always_comb begin
    eligible = req;
    if (state == LOCKED && req[sel]) begin
      eligible      = 4'b0000;
      eligible[sel] = 1'b1;
    end
  end
`else
  assign eligible = req;
`endif

  rr_pick4 u_pick (
    .req    (eligible),
    .last   (sel),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // rst_n gates the grant so ack can never fire while held in reset.
  assign capture  = rst_n & slot_free & pick_any;
  assign ack      = capture ? pick_onehot : 4'b0000;
  assign win_data = words[pick_idx];

  // FSM and output registers: capture, drain or hold the output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= SEL_RST;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= win_data;
      sel       <= pick_idx;
      out_valid <= 1'b1;
`ifdef MUX4_ARB_LOCK_EN
      state     <= lock ? LOCKED : BUSY;
`else
      state     <= BUSY;
`endif
    end else if (out_valid && out_ready) begin
      // Consumed with nothing to replace it: empty the slot.
      out_valid <= 1'b0;
      state     <= IDLE;
`ifdef MUX4_ARB_LOCK_EN
    end else if (state == LOCKED && slot_free && !req[sel]) begin
      // Locked requester went away while the slot was free: release.
      state     <= IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter.
// Build with MUX4_ARB_LOCK_EN defined to include the burst-lock steps.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] in_data;
  logic       out_ready;
  logic [3:0] ack;
  logic [1:0] sel;
  logic [1:0] out_data;
  logic       out_valid;
`ifdef MUX4_ARB_LOCK_EN
  logic       lock;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX4_ARB_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .in_data   (in_data),
    .ack       (ack),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_ack  [5];
  logic [1:0] rr_sel  [5];
  logic [1:0] rr_data [5];

  initial begin
    rr_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_sel  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    rr_data = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
`ifdef MUX4_ARB_LOCK_EN
    lock = 1'b0;
`endif

    // 1 Reset with random requests
    rst_n     = 1'b1;
    req       = 4'b0000;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #1 rst_n  = 1'b0;
    req       = 4'($urandom_range(1, 15));
    in_data   = 8'($urandom);
    out_ready = 1'b1;
    #1;
    chk("rst_valid", {3'b0, out_valid}, 4'b0000);
    chk("rst_data",  {2'b0, out_data},  4'b0000);
    chk("rst_sel",   {2'b0, sel},       4'b0011);
    chk("rst_ack",   ack,               4'b0000);
    tick();
    tick();
    chk("rst_ack_hold",  ack,               4'b0000);
    chk("rst_valid_hold",{3'b0, out_valid}, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
    chk("idle_valid", {3'b0, out_valid}, 4'b0000);

    // 3 Round-robin, all four requesting, d=01 c=11 b=00 a=10
    in_data   = 8'b01_11_00_10;
    out_ready = 1'b1;
    req       = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_ack%0d", i), ack, rr_ack[i]);
      tick();
      chk($sformatf("rr_sel%0d", i),  {2'b0, sel},      {2'b0, rr_sel[i]});
      chk($sformatf("rr_data%0d", i), {2'b0, out_data}, {2'b0, rr_data[i]});
      chk($sformatf("rr_valid%0d", i),{3'b0, out_valid}, 4'b0001);
    end
    req = 4'b0000;
    #1;
    chk("drain_ack", ack, 4'b0000);
    tick();
    chk("drain_valid", {3'b0, out_valid}, 4'b0000);
    chk("drain_data",  {2'b0, out_data},  4'b0010);
    chk("drain_sel",   {2'b0, sel},       4'b0000);

    // 2 Single request from c
    in_data = 8'b00_11_00_00;
    req     = 4'b0100;
    #1;
    chk("single_ack", ack, 4'b0100);
    tick();
    req = 4'b0000;
    chk("single_data",  {2'b0, out_data},  4'b0011);
    chk("single_sel",   {2'b0, sel},       4'b0010);
    chk("single_valid", {3'b0, out_valid}, 4'b0001);

    // 4 Stall: slot full, downstream not ready, b requesting (b=01)
    out_ready = 1'b0;
    in_data   = 8'b00_11_01_00;
    req       = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_ack%0d", i), ack, 4'b0000);
      tick();
      chk($sformatf("stall_data%0d", i),  {2'b0, out_data},  4'b0011);
      chk($sformatf("stall_sel%0d", i),   {2'b0, sel},       4'b0010);
      chk($sformatf("stall_valid%0d", i), {3'b0, out_valid}, 4'b0001);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_ack", ack, 4'b0010);
    tick();
    req = 4'b0000;
    chk("unstall_data", {2'b0, out_data}, 4'b0001);
    chk("unstall_sel",  {2'b0, sel},      4'b0001);

    // 5 Wrap/skip: move sel to 2, then req=0011 twice
    in_data = 8'b00_10_01_11;
    req     = 4'b0100;
    #1;
    chk("wrap_pre_ack", ack, 4'b0100);
    tick();
    chk("wrap_pre_sel", {2'b0, sel}, 4'b0010);
    req = 4'b0011;
    #1;
    chk("wrap_ack0", ack, 4'b0001);
    tick();
    chk("wrap_sel0",  {2'b0, sel},      4'b0000);
    chk("wrap_data0", {2'b0, out_data}, 4'b0011);
    #1;
    chk("wrap_ack1", ack, 4'b0010);
    tick();
    chk("wrap_sel1",  {2'b0, sel},      4'b0001);
    chk("wrap_data1", {2'b0, out_data}, 4'b0001);
    req = 4'b0000;
    tick();
    chk("wrap_drain", {3'b0, out_valid}, 4'b0000);

    // 6 Mid-transfer reset with word stalled in the slot
    req = 4'b0100;
    #1;
    tick();
    req       = 4'b0000;
    out_ready = 1'b0;
    chk("mid_sel_before",   {2'b0, sel},       4'b0010);
    chk("mid_valid_before", {3'b0, out_valid}, 4'b0001);
    #2 rst_n = 1'b0;
    req = 4'b1111;
    #1;
    chk("mid_valid", {3'b0, out_valid}, 4'b0000);
    chk("mid_data",  {2'b0, out_data},  4'b0000);
    chk("mid_sel",   {2'b0, sel},       4'b0011);
    chk("mid_ack",   ack,               4'b0000);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ack", ack, 4'b0001);
    tick();
    chk("post_rst_sel", {2'b0, sel}, 4'b0000);
    req = 4'b0000;
    tick();

`ifdef MUX4_ARB_LOCK_EN
    // 7 Burst lock starting from requester 0
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req  = 4'b1111;
    lock = 1'b1;
    #1;
    chk("lock_ack0", ack, 4'b0001);
    tick();
    for (int i = 1; i < 4; i++) begin
      if (i == 3) lock = 1'b0;
      #1;
      chk($sformatf("lock_ack%0d", i), ack, 4'b0001);
      tick();
      chk($sformatf("lock_sel%0d", i), {2'b0, sel}, 4'b0000);
    end
    #1;
    chk("unlock_ack", ack, 4'b0010);
    tick();
    chk("unlock_sel", {2'b0, sel}, 4'b0001);
    req = 4'b0000;
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
